s_axis_rq_adapt_x4: RTL
=======================

Name: s_axis_rq_adapt_x4

Overview:
- Requester-request (RQ) adapter for the x4 128-bit UltraScale PHY path.
- Converts the legacy TLP stream from the LitePCIe core into the UltraScale s_axis_rq descriptor format.
- Legacy streams put the 3DW/4DW header in beat 0; UltraScale expects a 128-bit descriptor in beat 0.
- 3DW-with-data packets have their payload realigned by one DW.

Parameters:
- DATA_WIDTH, 128, datapath width; only 128 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, byte-enable width of the legacy side.
- KEEP_WIDTH_A, DATA_WIDTH/32, DW-enable width of the core side.

Ports:
- user_clk  in  1  clock
- user_reset  in  1  synchronous active-high reset
- s_axis_rq_tdata  in  128  legacy TLP data; DW0 in [31:0]
- s_axis_rq_tkeep  in  16  legacy byte enables
- s_axis_rq_tlast  in  1  legacy end of packet
- s_axis_rq_tready  out  1  legacy ready
- s_axis_rq_tuser  in  4  [3] discontinue, [2:0] reserved
- s_axis_rq_tvalid  in  1  legacy valid
- s_axis_rq_tdata_a  out  128  descriptor/payload to PHY
- s_axis_rq_tkeep_a  out  4  DW enables
- s_axis_rq_tlast_a  out  1  end of packet
- s_axis_rq_tready_a  in  4  PHY ready; only bit 0 is used
- s_axis_rq_tuser_a  out  60  [3:0] first_be, [7:4] last_be, [10:8] addr_offset = 0, [11] discontinue, rest 0
- s_axis_rq_tvalid_a  out  1  PHY valid

Behaviour:
- One registered output stage; latency is 1 cycle from input accept to output valid.
- Load condition: ld = s_axis_rq_tvalid && s_axis_rq_tready.
- s_axis_rq_tready = (!s_axis_rq_tvalid_a || s_axis_rq_tready_a[0]) && state != TAIL.
- Reset values: s_axis_rq_tvalid_a = 0, tlast_a = 0, tdata_a = 0, tkeep_a = 0, tuser_a = 0, state = SOP.
- Reset mid-packet discards the residual DW and the partial packet.
- Header decode from beat 0:
  - DW0: fmt = [31:29], type = [28:24], tc = [22:20], ep = [14], attr = [13:12], len = [9:0].
  - DW1: reqid = [31:16], tag = [15:8], lbe = [7:4], fbe = [3:0].
  - 4DW header: address = {DW2, DW3[31:2]}. 3DW header: address = {32'h0, DW2[31:2]}.
- Request type: MRd 4'b0000, MWr 4'b0001, IORd 4'b0010, IOWr 4'b0011. Any other fmt/type is unsupported.
- Descriptor fields:
  - [1:0] = 00; [63:2] = address.
  - [74:64] = dword count; len = 0 encodes 11'd1024.
  - [78:75] = request type; [79] = ep.
  - [95:80] = reqid; [103:96] = tag; [119:104] = 0; [120] = 0.
  - [123:121] = tc; [126:124] = {1'b0, attr}; [127] = 0.
  - Descriptor beat: tkeep_a = 4'hF; tuser_a carries fbe/lbe.
- States:
  - SOP: decode beat 0 and emit the descriptor.
    - Unsupported type -> DROP (nothing emitted), or stay in SOP if tlast.
    - No data (fmt[1] = 0) -> emit descriptor with tlast_a = 1, stay in SOP.
    - 4DW with data -> PASS.
    - 3DW with data -> save DW3 in res and set res_v; go to SHIFT. If tlast is also set, go to TAIL.
  - PASS: payload passes through unchanged. tkeep_a[i] = s_axis_rq_tkeep[4i]. tlast -> SOP.
  - SHIFT: output = {in[95:0], res}; res <= in[127:96].
    - tlast with in DW3 kept -> TAIL, output tlast_a = 0.
    - tlast with in DW3 not kept -> emit with tlast_a = 1, go to SOP.
    - tkeep_a = {keep[8], keep[4], keep[0], 1'b1}.
  - TAIL: input stalled. When the output stage is free, emit {96'h0, res} with tkeep_a = 4'h1 and tlast_a = 1, go to SOP.
  - DROP: accept and discard beats; tlast -> SOP.
- Discontinue: s_axis_rq_tuser[3] maps to tuser_a[11] on the same beat. In SHIFT it is also carried onto the TAIL beat.
- tuser_a[3:0] and [7:4] are non-zero only on the descriptor beat.
- Back-pressure: if tvalid_a && !tready_a[0], the output register holds stable and no input is accepted.

Optional Feature:
- Macro: RQ_ADAPT_UNSUP_CNT_EN.
- When defined: adds output port unsup_cnt [15:0], a saturating count of dropped unsupported packets.
  - Incremented at SOP acceptance of an unsupported header; saturates at 16'hFFFF.
  - Cleared by user_reset.
- When undefined: no port and no counter; drop behaviour is identical.

Decomposition:
- Package litepcie_rq_pkg holds:
  - Request-type codes and fmt/type encodings.
  - Descriptor field bit positions.
  - State enum {SOP, PASS, SHIFT, TAIL, DROP}.
- One sub-module, rq_desc_build: combinational legacy header -> 128-bit descriptor plus fbe/lbe.

Test Plan:
- 3DW MRd, len = 1, addr 0x1000_0040, tag 0x12, fbe 0xF -> one beat:
  - [63:2] = 0x0400_0010, [74:64] = 1, [78:75] = 0, tlast_a = 1, tuser_a[3:0] = 0xF.
- 4DW MWr, len = 4, addr 0x1_2345_6780, payload D0..D3 -> descriptor beat, then D0..D3 unshifted with tkeep_a = 0xF and tlast_a = 1.
- 3DW MWr, len = 4, beat0 DW3 = D0, beat1 = D1..D3 + pad with tkeep 0x0FFF:
  - Output: descriptor, then {D3, D2, D1, D0} with tkeep_a = 0xF and tlast_a = 1; no TAIL beat.
- 3DW MWr, len = 5 -> descriptor, {D3..D0}, then TAIL beat {D4} with tkeep_a = 0x1 and tlast_a = 1. s_axis_rq_tready = 0 during TAIL.
- Random tready_a[0] toggling on the 4DW MWr len = 8 case -> output sequence is identical and data holds stable under stall.
- Cfg-type header (type 00100), 2 beats, followed by MRd -> no output for the cfg packet, the MRd is emitted normally, unsup_cnt = 1 (if enabled).
- user_reset asserted mid-SHIFT -> tvalid_a = 0 and state = SOP next cycle; the following packet is correct.

Source files
------------

// File: rtl/litepcie_rq_pkg.sv
// -----------------------------------------------------------------------------
// litepcie_rq_pkg
// Shared definitions for the UltraScale x4 requester-request adapter:
//   - legacy TLP fmt/type encodings and UltraScale request-type codes
//   - bit positions of the fields inside the 128-bit RQ descriptor
//   - adapter state enumeration
//   - dword-count helper (a legacy length of 0 means 1024 DW)
// -----------------------------------------------------------------------------
package litepcie_rq_pkg;

   typedef enum logic [2:0] {
      SOP   = 3'd0,
      PASS  = 3'd1,
      SHIFT = 3'd2,
      TAIL  = 3'd3,
      DROP  = 3'd4
   } rq_state_e;

   // UltraScale request-type codes
   localparam logic [3:0] REQ_MRD  = 4'b0000;
   localparam logic [3:0] REQ_MWR  = 4'b0001;
   localparam logic [3:0] REQ_IORD = 4'b0010;
   localparam logic [3:0] REQ_IOWR = 4'b0011;

   // Legacy TLP type field values
   localparam logic [4:0] TYPE_MEM = 5'b00000;
   localparam logic [4:0] TYPE_IO  = 5'b00010;

   // Descriptor field positions
   localparam int DESC_ADDR_LSB  = 2;
   localparam int DESC_ADDR_MSB  = 63;
   localparam int DESC_DWC_LSB   = 64;
   localparam int DESC_DWC_MSB   = 74;
   localparam int DESC_REQ_LSB   = 75;
   localparam int DESC_REQ_MSB   = 78;
   localparam int DESC_EP        = 79;
   localparam int DESC_REQID_LSB = 80;
   localparam int DESC_REQID_MSB = 95;
   localparam int DESC_TAG_LSB   = 96;
   localparam int DESC_TAG_MSB   = 103;
   localparam int DESC_TC_LSB    = 121;
   localparam int DESC_TC_MSB    = 123;
   localparam int DESC_ATTR_LSB  = 124;
   localparam int DESC_ATTR_MSB  = 126;

   // Legacy 10-bit length to 11-bit UltraScale dword count
   function automatic logic [10:0] dw_count(input logic [9:0] len);
      return (len == 10'd0) ? 11'd1024 : {1'b0, len};
   endfunction

endpackage

// File: rtl/s_axis_rq_adapt_x4_if.sv
// -----------------------------------------------------------------------------
// s_axis_rq_adapt_x4_if
// Bundles both sides of the RQ adapter:
//   legacy side : s_axis_rq_tdata/tkeep/tlast/tuser/tvalid in, s_axis_rq_tready out
//   PHY side    : s_axis_rq_tdata_a/tkeep_a/tlast_a/tuser_a/tvalid_a out,
//                 s_axis_rq_tready_a in
// Modports:
//   slave  - the adapter (sink of the legacy stream, source of the PHY stream)
//   master - the environment around it (legacy source, PHY sink)
// -----------------------------------------------------------------------------
interface s_axis_rq_adapt_x4_if;
   logic [127:0] s_axis_rq_tdata;
   logic [15:0]  s_axis_rq_tkeep;
   logic         s_axis_rq_tlast;
   logic         s_axis_rq_tready;
   logic [3:0]   s_axis_rq_tuser;
   logic         s_axis_rq_tvalid;

   logic [127:0] s_axis_rq_tdata_a;
   logic [3:0]   s_axis_rq_tkeep_a;
   logic         s_axis_rq_tlast_a;
   logic [3:0]   s_axis_rq_tready_a;
   logic [59:0]  s_axis_rq_tuser_a;
   logic         s_axis_rq_tvalid_a;

   modport slave (
      input  s_axis_rq_tdata, s_axis_rq_tkeep, s_axis_rq_tlast,
             s_axis_rq_tuser, s_axis_rq_tvalid,
      output s_axis_rq_tready,
      output s_axis_rq_tdata_a, s_axis_rq_tkeep_a, s_axis_rq_tlast_a,
             s_axis_rq_tuser_a, s_axis_rq_tvalid_a,
      input  s_axis_rq_tready_a
   );

   modport master (
      output s_axis_rq_tdata, s_axis_rq_tkeep, s_axis_rq_tlast,
             s_axis_rq_tuser, s_axis_rq_tvalid,
      input  s_axis_rq_tready,
      input  s_axis_rq_tdata_a, s_axis_rq_tkeep_a, s_axis_rq_tlast_a,
             s_axis_rq_tuser_a, s_axis_rq_tvalid_a,
      output s_axis_rq_tready_a
   );
endinterface

// File: rtl/rq_desc_build.sv
// -----------------------------------------------------------------------------
// rq_desc_build
// Combinational translation of a legacy 3DW/4DW TLP header (beat 0) into the
// 128-bit UltraScale RQ descriptor.
// Ports:
//   hdr_i       - legacy beat 0, DW0 in [31:0]
//   desc_o      - UltraScale descriptor
//   fbe_o/lbe_o - first/last byte enables from DW1
//   supported_o - header is MRd/MWr/IORd/IOWr
//   has_data_o  - fmt[1], packet carries payload
//   is_4dw_o    - fmt[0], 4DW header
// -----------------------------------------------------------------------------
module rq_desc_build
   import litepcie_rq_pkg::*;
(
   input  logic [127:0] hdr_i,
   output logic [127:0] desc_o,
   output logic [3:0]   fbe_o,
   output logic [3:0]   lbe_o,
   output logic         supported_o,
   output logic         has_data_o,
   output logic         is_4dw_o
);
   logic [31:0] dw0, dw1, dw2, dw3;
   logic [2:0]  fmt;
   logic [4:0]  typ;
   logic [3:0]  req;
   logic [61:0] addr;
   logic        unused_ok;

   assign dw0 = hdr_i[31:0];
   assign dw1 = hdr_i[63:32];
   assign dw2 = hdr_i[95:64];
   assign dw3 = hdr_i[127:96];
   assign fmt = dw0[31:29];
   assign typ = dw0[28:24];

   assign has_data_o = fmt[1];
   assign is_4dw_o   = fmt[0];
   assign fbe_o      = dw1[3:0];
   assign lbe_o      = dw1[7:4];
   assign addr       = fmt[0] ? {dw2, dw3[31:2]} : {32'h0, dw2[31:2]};

   // Request-type classification; IO requests only exist with a 3DW header
   always_comb begin
      req         = REQ_MRD;
      supported_o = 1'b0;
      case (typ)
         TYPE_MEM: begin
            req         = fmt[1] ? REQ_MWR : REQ_MRD;
            supported_o = ~fmt[2];
         end
         TYPE_IO: begin
            req         = fmt[1] ? REQ_IOWR : REQ_IORD;
            supported_o = ~fmt[2] & ~fmt[0];
         end
         default: begin
            req         = REQ_MRD;
            supported_o = 1'b0;
         end
      endcase
   end

   // Descriptor assembly; all reserved bits stay zero
   always_comb begin
      desc_o                                = 128'h0;
      desc_o[DESC_ADDR_MSB:DESC_ADDR_LSB]   = addr;
      desc_o[DESC_DWC_MSB:DESC_DWC_LSB]     = dw_count(dw0[9:0]);
      desc_o[DESC_REQ_MSB:DESC_REQ_LSB]     = req;
      desc_o[DESC_EP]                       = dw0[14];
      desc_o[DESC_REQID_MSB:DESC_REQID_LSB] = dw1[31:16];
      desc_o[DESC_TAG_MSB:DESC_TAG_LSB]     = dw1[15:8];
      desc_o[DESC_TC_MSB:DESC_TC_LSB]       = dw0[22:20];
      desc_o[DESC_ATTR_MSB:DESC_ATTR_LSB]   = {1'b0, dw0[13:12]};
   end

   assign unused_ok = ^{dw0[23], dw0[19:15], dw0[11:10], dw3[1:0]};
endmodule

// File: rtl/s_axis_rq_adapt_x4.sv
// -----------------------------------------------------------------------------
// s_axis_rq_adapt_x4
// Legacy LitePCIe RQ TLP stream -> UltraScale x4 128-bit s_axis_rq format.
// Beat 0 header is replaced by a 128-bit descriptor; 3DW-with-data payload is
// realigned down by one DW. One registered output stage, 1-cycle latency.
// Ports:
//   user_clk, user_reset - clock, synchronous active-high reset
//   rq (slave modport)   - legacy input stream and PHY output stream
//   unsup_cnt            - saturating count of dropped unsupported packets
//                          (present only with RQ_ADAPT_UNSUP_CNT_EN defined)
// Optional feature macro: RQ_ADAPT_UNSUP_CNT_EN
// -----------------------------------------------------------------------------
module s_axis_rq_adapt_x4
   import litepcie_rq_pkg::*;
#(
   parameter int DATA_WIDTH   = 128,
   parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
   parameter int KEEP_WIDTH_A = DATA_WIDTH / 32
)(
   input  logic                user_clk,
   input  logic                user_reset,
   s_axis_rq_adapt_x4_if.slave rq
`ifdef RQ_ADAPT_UNSUP_CNT_EN
   ,
   output logic [15:0]         unsup_cnt
`endif
);
   rq_state_e               state_q;
   logic [DATA_WIDTH-1:0]   tdata_q;
   logic [KEEP_WIDTH_A-1:0] tkeep_q;
   logic                    tlast_q;
   logic [59:0]             tuser_q;
   logic                    tvalid_q;
   logic [31:0]             res_q;       // DW held back by the one-DW realignment
   logic                    res_disc_q;  // discontinue to replay on the TAIL beat

   logic [KEEP_WIDTH-1:0]   keep;
   logic [KEEP_WIDTH_A-1:0] keep_pass;
   logic [KEEP_WIDTH_A-1:0] keep_shift;
   logic [127:0]            desc;
   logic [3:0]              fbe, lbe;
   logic                    sup, has_data, is_4dw;
   logic                    out_free, ld, disc, unused_ok;

   rq_desc_build u_desc (
      .hdr_i       (rq.s_axis_rq_tdata),
      .desc_o      (desc),
      .fbe_o       (fbe),
      .lbe_o       (lbe),
      .supported_o (sup),
      .has_data_o  (has_data),
      .is_4dw_o    (is_4dw)
   );

   assign keep     = rq.s_axis_rq_tkeep;
   assign disc     = rq.s_axis_rq_tuser[3];
   assign out_free = ~tvalid_q | rq.s_axis_rq_tready_a[0];
   assign rq.s_axis_rq_tready = out_free && (state_q != TAIL);
   assign ld       = rq.s_axis_rq_tvalid & rq.s_axis_rq_tready;
   // Shifted beat: output DW0 is the held residual, DW1..3 are input DW0..2
   assign keep_shift = {keep[8], keep[4], keep[0], 1'b1};

   // Byte enables collapsed to one enable per DW
   always_comb begin
      keep_pass = '0;
      for (int i = 0; i < KEEP_WIDTH_A; i++) begin
         keep_pass[i] = keep[4*i];
      end
   end

   // Packet FSM and registered output stage; everything holds while stalled
   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         state_q    <= SOP;
         tdata_q    <= '0;
         tkeep_q    <= '0;
         tlast_q    <= 1'b0;
         tuser_q    <= 60'h0;
         tvalid_q   <= 1'b0;
         res_q      <= 32'h0;
         res_disc_q <= 1'b0;
      end else if (out_free) begin
         tvalid_q <= 1'b0;
         case (state_q)
            SOP: begin
               if (ld) begin
                  if (!sup) begin
                     state_q <= rq.s_axis_rq_tlast ? SOP : DROP;
                  end else begin
                     tvalid_q <= 1'b1;
                     tdata_q  <= desc;
                     tkeep_q  <= 4'hF;
                     tuser_q  <= {48'h0, disc, 3'b000, lbe, fbe};
                     tlast_q  <= ~has_data;
                     if (!has_data) begin
                        state_q <= SOP;
                     end else if (is_4dw) begin
                        state_q <= PASS;
                     end else begin
                        // 3DW: first payload DW already sits in DW3 of beat 0
                        res_q      <= rq.s_axis_rq_tdata[127:96];
                        res_disc_q <= disc;
                        state_q    <= rq.s_axis_rq_tlast ? TAIL : SHIFT;
                     end
                  end
               end
            end
            PASS: begin
               if (ld) begin
                  tvalid_q <= 1'b1;
                  tdata_q  <= rq.s_axis_rq_tdata;
                  tkeep_q  <= keep_pass;
                  tlast_q  <= rq.s_axis_rq_tlast;
                  tuser_q  <= {48'h0, disc, 11'h000};
                  state_q  <= rq.s_axis_rq_tlast ? SOP : PASS;
               end
            end
            SHIFT: begin
               if (ld) begin
                  tvalid_q   <= 1'b1;
                  tdata_q    <= {rq.s_axis_rq_tdata[95:0], res_q};
                  tkeep_q    <= keep_shift;
                  tuser_q    <= {48'h0, disc, 11'h000};
                  res_q      <= rq.s_axis_rq_tdata[127:96];
                  res_disc_q <= disc;
                  // A kept input DW3 still has to go out on its own TAIL beat
                  tlast_q    <= rq.s_axis_rq_tlast & ~keep[12];
                  if (rq.s_axis_rq_tlast) begin
                     state_q <= keep[12] ? TAIL : SOP;
                  end else begin
                     state_q <= SHIFT;
                  end
               end
            end
            TAIL: begin
               tvalid_q <= 1'b1;
               tdata_q  <= {96'h0, res_q};
               tkeep_q  <= 4'h1;
               tlast_q  <= 1'b1;
               tuser_q  <= {48'h0, res_disc_q, 11'h000};
               state_q  <= SOP;
            end
            DROP: begin
               if (ld && rq.s_axis_rq_tlast) begin
                  state_q <= SOP;
               end else begin
                  state_q <= DROP;
               end
            end
            default: begin
               state_q <= SOP;
            end
         endcase
      end
   end

   assign rq.s_axis_rq_tdata_a  = tdata_q;
   assign rq.s_axis_rq_tkeep_a  = tkeep_q;
   assign rq.s_axis_rq_tlast_a  = tlast_q;
   assign rq.s_axis_rq_tuser_a  = tuser_q;
   assign rq.s_axis_rq_tvalid_a = tvalid_q;

`ifdef RQ_ADAPT_UNSUP_CNT_EN
   logic [15:0] unsup_q;

   // Saturating count of unsupported headers accepted at start of packet
   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         unsup_q <= 16'h0;
      end else if ((state_q == SOP) && ld && !sup && (unsup_q != 16'hFFFF)) begin
         unsup_q <= unsup_q + 16'h1;
      end else begin
         unsup_q <= unsup_q;
      end
   end

   assign unsup_cnt = unsup_q;
`endif

   assign unused_ok = ^{rq.s_axis_rq_tuser[2:0], rq.s_axis_rq_tready_a[3:1], keep};
endmodule
